// File: rtl/block_code_rx.sv
// Receive-side checker/decoder for the {data, ~data} 16-bit complement block code.
// Forwards the data byte with error flag/mask, tracks link lock and a saturating error count.
module block_code_rx #(
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_GOOD = 4,
  parameter int LOSS_BAD  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cw_valid,
  output logic                 cw_ready,
  input  logic [15:0]          cw_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_err,
  output logic [7:0]           out_errmask,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam int RUN_MAX = (LOCK_GOOD > LOSS_BAD) ? LOCK_GOOD : LOSS_BAD;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_LAST = RUN_W'(LOCK_GOOD - 1);
  localparam logic [RUN_W-1:0] BAD_LAST  = RUN_W'(LOSS_BAD - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] good_run, good_run_nxt;
  logic [RUN_W-1:0] bad_run, bad_run_nxt;
  logic             accept;
  logic [7:0]       mask;
  logic             word_err;

  // The single output slot can be refilled on the same edge it is drained.
  assign cw_ready = ~out_valid | out_ready;
  assign accept   = cw_valid & cw_ready;
  assign mask     = cw_data[15:8] ^ ~cw_data[7:0];
  assign word_err = |mask;
  assign locked   = (state == LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_errmask <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= cw_data[15:8];
      out_err     <= word_err;
      out_errmask <= mask;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= good_run_nxt;
      bad_run  <= bad_run_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    if (accept) begin
      unique case (state)
        SEARCH: begin
          if (word_err) begin
            good_run_nxt = '0;
          end else if (good_run >= GOOD_LAST) begin
            state_nxt    = LOCKED;
            good_run_nxt = '0;
            bad_run_nxt  = '0;
          end else begin
            good_run_nxt = good_run + 1'b1;
            bad_run_nxt  = '0;
          end
        end
        LOCKED: begin
          if (!word_err) begin
            bad_run_nxt = '0;
          end else if (bad_run >= BAD_LAST) begin
            state_nxt    = SEARCH;
            good_run_nxt = '0;
            bad_run_nxt  = '0;
          end else begin
            bad_run_nxt = bad_run + 1'b1;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Clear has priority over a simultaneous error increment.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_count <= '0;
    end else if (accept && word_err && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_block_code_rx.sv
// Directed self-checking bench for block_code_rx (error counter narrowed to 4 bits).
module tb_block_code_rx;

  localparam int ERR_CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cw_valid;
  logic                 cw_ready;
  logic [15:0]          cw_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_err;
  logic [7:0]           out_errmask;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clr;

  int n_vec  = 0;
  int n_miss = 0;

  block_code_rx #(.ERR_CNT_W(ERR_CNT_W), .LOCK_GOOD(4), .LOSS_BAD(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .cw_data     (cw_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_errmask (out_errmask),
    .locked      (locked),
    .err_count   (err_count),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    cw_valid = 1'b1;
    cw_data  = 16'hA55A;
    out_ready = 1'b1;
    err_clr  = 1'b0;

    // Reset held two edges with traffic offered
    tick();
    tick();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst locked", 32'(locked), 0);
    check("rst err_count", 32'(err_count), 0);
    check("rst cw_ready", 32'(cw_ready), 1);
    check("rst out_data", 32'(out_data), 0);
    check("rst out_errmask", 32'(out_errmask), 0);

    // Lock on four back-to-back good words
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lock%0d out_valid", i), 32'(out_valid), 1);
      check($sformatf("lock%0d out_data", i), 32'(out_data), 32'hA5);
      check($sformatf("lock%0d out_err", i), 32'(out_err), 0);
      check($sformatf("lock%0d cw_ready", i), 32'(cw_ready), 1);
      check($sformatf("lock%0d locked", i), 32'(locked), (i == 3) ? 1 : 0);
    end

    // Single-bit error, then two more bad words drop the lock
    cw_data = 16'hA55B;
    tick();
    check("err1 out_err", 32'(out_err), 1);
    check("err1 out_errmask", 32'(out_errmask), 32'h01);
    check("err1 out_data", 32'(out_data), 32'hA5);
    check("err1 err_count", 32'(err_count), 1);
    check("err1 locked", 32'(locked), 1);
    cw_data = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bad%0d out_errmask", i), 32'(out_errmask), 32'hFF);
      check($sformatf("bad%0d locked", i), 32'(locked), (i == 0) ? 1 : 0);
    end
    check("err4 err_count", 32'(err_count), 4);

    // Backpressure: hold the output for 5 clocks, then retire+accept together
    cw_data = 16'h3CC3;
    tick();
    check("bp first out_data", 32'(out_data), 32'h3C);
    out_ready = 1'b0;
    cw_data   = 16'h5AA5;
    #1;
    check("bp cw_ready low", 32'(cw_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d out_valid", i), 32'(out_valid), 1);
      check($sformatf("bp%0d out_data", i), 32'(out_data), 32'h3C);
      check($sformatf("bp%0d cw_ready", i), 32'(cw_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp cw_ready high", 32'(cw_ready), 1);
    tick();
    check("bp swap out_valid", 32'(out_valid), 1);
    check("bp swap out_data", 32'(out_data), 32'h5A);
    cw_valid = 1'b0;
    tick();
    check("bp drain out_valid", 32'(out_valid), 0);
    check("bp err_count", 32'(err_count), 4);
    check("bp locked", 32'(locked), 0);

    // Saturation of the 4-bit counter, then clear beats a same-edge error
    cw_valid = 1'b1;
    cw_data  = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9)  check("sat mid err_count", 32'(err_count), 14);
      if (i == 10) check("sat top err_count", 32'(err_count), 15);
    end
    check("sat end err_count", 32'(err_count), 15);
    err_clr = 1'b1;
    tick();
    check("clr out_err", 32'(out_err), 1);
    check("clr err_count", 32'(err_count), 0);
    err_clr  = 1'b0;
    cw_valid = 1'b0;
    tick();
    check("clr hold err_count", 32'(err_count), 0);

    // Relock after one bad word, then reset mid-stream while holding a word
    cw_valid = 1'b1;
    cw_data  = 16'hA55B;
    tick();
    cw_data = 16'hA55A;
    for (int i = 0; i < 4; i++) tick();
    check("pre-rst locked", 32'(locked), 1);
    check("pre-rst err_count", 32'(err_count), 1);
    out_ready = 1'b0;
    tick();
    check("pre-rst out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    tick();
    check("mid-rst out_valid", 32'(out_valid), 0);
    check("mid-rst locked", 32'(locked), 0);
    check("mid-rst err_count", 32'(err_count), 0);
    check("mid-rst out_data", 32'(out_data), 0);
    check("mid-rst out_err", 32'(out_err), 0);
    check("mid-rst out_errmask", 32'(out_errmask), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("relock%0d locked", i), 32'(locked), (i == 3) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
